// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, LATENCY wait cycles, then a held response.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned/illegal accesses on rsp_err_o instead of silently aligning.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY == 0 ? 0 : LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            access;
  logic            write_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      funct3_q;

  logic            acc_write;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  logic [2:0]      acc_f3;
  logic [AW-1:0]   acc_idx;
  logic            acc_ok;
  logic            resp_ok;
  logic [3:0]      be;
  logic [31:0]     rword;
  logic [31:0]     byte_sh;
  logic [31:0]     half_sh;

  wire unused_addr_hi = ^req_addr_i[31:AW+2];

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 0) begin
            state_d = S_RESP;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req_valid_i) begin
        write_q  <= req_write_i;
        addr_q   <= req_addr_i[AW+1:0];
        wdata_q  <= req_wdata_i;
        funct3_q <= req_funct3_i;
      end
    end
  end

  // With LATENCY=0 the access happens on the accept edge, before the request is latched.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = req_write_i;
      acc_addr  = req_addr_i[AW+1:0];
      acc_wdata = req_wdata_i;
      acc_f3    = req_funct3_i;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_f3    = funct3_q;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign acc_ok  = f3_legal(acc_f3) && !misaligned(acc_f3, acc_addr[1:0]);
  assign resp_ok = f3_legal(funct3_q) && !misaligned(funct3_q, addr_q[1:0]);
`else
  assign acc_ok  = f3_legal(acc_f3);
  assign resp_ok = f3_legal(funct3_q);
`endif

  always_comb begin
    case (acc_f3[1:0])
      2'b00:   be = 4'b0001 << acc_addr[1:0];
      2'b01:   be = acc_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // One byte-wide storage array per lane so byte enables map onto independent RAMs.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS] = '{default: 8'h00};
    logic [7:0] rd_q;
    logic [7:0] wr_byte;

    always_comb begin
      case (acc_f3[1:0])
        2'b00:   wr_byte = acc_wdata[7:0];
        2'b01:   wr_byte = acc_wdata[8*(gi%2) +: 8];
        default: wr_byte = acc_wdata[8*gi +: 8];
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (!rst_i && access && acc_write && acc_ok && be[gi]) mem_q[acc_idx] <= wr_byte;
      if (access) rd_q <= mem_q[acc_idx];
    end

    assign rword[8*gi +: 8] = rd_q;
  end

  assign byte_sh = rword >> {addr_q[1:0], 3'b000};
  assign half_sh = rword >> {addr_q[1], 4'b0000};

  always_comb begin
    rsp_rdata_o = 32'd0;
    if (state_q == S_RESP && !write_q && resp_ok) begin
      case (funct3_q)
        3'b000:  rsp_rdata_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
        3'b100:  rsp_rdata_o = {24'd0, byte_sh[7:0]};
        3'b001:  rsp_rdata_o = {{16{half_sh[15]}}, half_sh[15:0]};
        3'b101:  rsp_rdata_o = {16'd0, half_sh[15:0]};
        3'b010:  rsp_rdata_o = rword;
        default: rsp_rdata_o = 32'd0;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign rsp_err_o = (state_q == S_RESP) && !resp_ok;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan steps then random traffic against a byte-array reference model.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0] model_mem [4*DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_funct3_i(req_funct3),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory is a flat byte array; an access touches `size` bytes starting at the aligned base.
  function automatic void model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [2:0] f3, output logic [31:0] rdata, output logic err);
    int size, base;
    logic legal, mis;
    logic [31:0] v;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size  = 1 << f3[1:0];
    mis   = (addr % size) != 0;
    base  = int'(addr % (4 * DEPTH));
    base  = base - (base % size);
    rdata = 32'd0;
    err   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    err = !legal || mis;
    if (err) return;
`else
    if (!legal || (mis && 1'b0)) return;
`endif
    if (wr) begin
      for (int i = 0; i < size; i++) model_mem[base + i] = wdata[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(model_mem[base + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      rdata = v;
    end
  endfunction

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                     input int bp, input string tag, output logic [31:0] rdata, output logic err);
    int cyc;
    logic [31:0] exp_d;
    logic exp_e;
    model_access(wr, addr, wdata, f3, exp_d, exp_e);
    @(negedge clk);
    check({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(posedge clk); #1;
    // Keep a garbage request asserted through WAIT/RESP; it must be ignored.
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 40);
    check({tag, "/latency"}, 32'(cyc), 32'(LAT + 1));
    rdata = rsp_rdata;
    err   = rsp_err;
    check({tag, "/rdata"}, rsp_rdata, exp_d);
    check({tag, "/err"}, 32'(rsp_err), 32'(exp_e));
    check({tag, "/resp_ready_low"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check({tag, "/bp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "/bp_rdata"}, rsp_rdata, exp_d);
      check({tag, "/bp_ready_low"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "/done_busy"}, 32'(busy), 32'd0);
    $display("txn %s wr=%0d addr=%h wdata=%h f3=%0d -> rdata=%h err=%0d", tag, wr, addr, wdata, f3, rdata, err);
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    for (int i = 0; i < 4 * DEPTH; i++) model_mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset/rdata", rsp_rdata, 32'd0);
    check("reset/err", 32'(rsp_err), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    rst = 1'b0;

    txn(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, "sw_10", d, e);
    check("sw_10/const", d, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 3'd2, 0, "lw_10", d, e);
    check("lw_10/const", d, 32'hDEADBEEF);
    txn(1'b1, 32'h11, 32'h7F, 3'd0, 0, "sb_11", d, e);
    txn(1'b0, 32'h10, 32'h0, 3'd2, 0, "lw_10b", d, e);
    check("lw_10b/const", d, 32'hDEAD7FEF);
    txn(1'b0, 32'h13, 32'h0, 3'd0, 0, "lb_13", d, e);
    check("lb_13/const", d, 32'hFFFFFFDE);
    txn(1'b0, 32'h13, 32'h0, 3'd4, 0, "lbu_13", d, e);
    check("lbu_13/const", d, 32'h000000DE);
    txn(1'b0, 32'h12, 32'h0, 3'd1, 0, "lh_12", d, e);
    check("lh_12/const", d, 32'hFFFFDEAD);
    txn(1'b0, 32'h12, 32'h0, 3'd5, 0, "lhu_12", d, e);
    check("lhu_12/const", d, 32'h0000DEAD);
    txn(1'b0, 32'h10, 32'h0, 3'd2, 5, "lw_bp", d, e);

    txn(1'b1, 32'h400, 32'h12345678, 3'd2, 0, "sw_wrap", d, e);
    txn(1'b0, 32'h0, 32'h0, 3'd2, 0, "lw_wrap", d, e);
    check("lw_wrap/const", d, 32'h12345678);

    // Reset one cycle after accepting a store: nothing may commit or respond.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAAAAAA; req_funct3 = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_wait/busy", 32'(busy), 32'd0);
    check("rst_wait/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wait/req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    $display("txn rst_wait sw addr=00000020 dropped by reset");
    txn(1'b0, 32'h20, 32'h0, 3'd2, 0, "lw_20", d, e);
    check("lw_20/const", d, 32'h00000000);

`ifdef DMEM_MISALIGN_TRAP_EN
    txn(1'b1, 32'h22, 32'h1, 3'd2, 0, "sw_mis", d, e);
    check("sw_mis/const_err", 32'(e), 32'd1);
    txn(1'b0, 32'h20, 32'h0, 3'd2, 0, "lw_20_after", d, e);
    check("lw_20_after/const", d, 32'h00000000);
`else
    txn(1'b1, 32'h23, 32'hBEEF, 3'd1, 0, "sh_mis", d, e);
    check("sh_mis/const_err", 32'(e), 32'd0);
    txn(1'b0, 32'h20, 32'h0, 3'd2, 0, "lw_20_after", d, e);
    check("lw_20_after/const", d, 32'hBEEF0000);
`endif
    txn(1'b0, 32'h10, 32'h0, 3'd3, 0, "ld_illegal", d, e);
    check("ld_illegal/const", d, 32'h00000000);
    txn(1'b1, 32'h10, 32'h55555555, 3'd6, 0, "st_illegal", d, e);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
      txn(1'($urandom), a, $urandom, 3'($urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n), d, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
